// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Flag vectors are ordered {negative, zero, carry_out, overflow}.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int FLAGS_W = 4;
    localparam int CTRL_W  = 4;
    localparam int CNT_W   = 4;

    localparam int NEG   = 3;
    localparam int ZERO  = 2;
    localparam int CARRY = 1;
    localparam int OVF   = 0;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bus between two requesters and the ALU arbiter.
// Valid/ready rule: a transfer happens on a rising edge where valid and ready are both high;
// the source holds its payload while valid is high and unaccepted, ready never waits on itself.
interface alu_arbiter_if #(
    parameter int N = 8
);
    import alu_arb_pkg::*;

    logic [1:0]                    req_valid;
    logic [1:0]                    req_ready;
    logic [1:0][N-1:0]             req_a;
    logic [1:0][N-1:0]             req_b;
    logic [1:0][CTRL_W-1:0]        req_ctrl;

    logic                          rsp_valid;
    logic                          rsp_ready;
    logic                          rsp_id;
    logic [N-1:0]                  rsp_data;
    logic [FLAGS_W-1:0]            rsp_flags;

    modport master (
        output req_valid, req_a, req_b, req_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags
    );

endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Combinational 2-way grant. Round-robin on contention by default;
// defining ALU_ARB_FIXED_PRIO_EN makes requester 0 win every contention.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id
);

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        grant_id = 1'b0;
        case (valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
            2'b11:   grant_id = 1'b0;
`else
            2'b11:   grant_id = ~last_grant;
`endif
            default: grant_id = 1'b0;
        endcase

        grant = 2'b00;
        if (valid != 2'b00) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two requesters: grant, drive registered operands,
// wait ALU_LAT cycles, capture result/flags into a held response. Option: ALU_ARB_FIXED_PRIO_EN.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N       = 8,
    parameter int ALU_LAT = 1
) (
    input  logic               clock,
    input  logic               reset,
    alu_arbiter_if.slave       bus,
    output logic [N-1:0]       alu_a,
    output logic [N-1:0]       alu_b,
    output logic [CTRL_W-1:0]  alu_ctrl,
    input  logic [N-1:0]       alu_result,
    input  logic [FLAGS_W-1:0] alu_flags,
    output logic               busy,
    output state_e             dbg_state
);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ALU_LAT - 1);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic               owner;
    logic               last_grant;
    logic [1:0]         grant;
    logic               grant_id;
    logic               take;

    logic               rsp_valid_q;
    logic               rsp_id_q;
    logic [N-1:0]       rsp_data_q;
    logic [FLAGS_W-1:0] rsp_flags_q;

    rr_arbiter2 u_arb (
        .valid      (bus.req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    // Ready is only offered in IDLE and is forced low while reset is held.
    assign bus.req_ready = (state == IDLE && !reset) ? grant : 2'b00;
    assign take          = |(bus.req_valid & bus.req_ready);

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign dbg_state     = state;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign last_grant = 1'b1;
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && take) begin
            last_grant <= grant_id;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            owner       <= 1'b0;
            busy        <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_ctrl    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        alu_a    <= bus.req_a[grant_id];
                        alu_b    <= bus.req_b[grant_id];
                        alu_ctrl <= bus.req_ctrl[grant_id];
                        owner    <= grant_id;
                        cnt      <= LAT_M1;
                        busy     <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_data_q  <= alu_result;
                        rsp_flags_q <= alu_flags;
                        rsp_id_q    <= owner;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    // Returning to IDLE first means the next grant lands a cycle later.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: one instance with ALU_LAT=1, one with ALU_LAT=3.
// Honours ALU_ARB_FIXED_PRIO_EN when choosing the expected contention grant order.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int N = 8;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  alu_arbiter_if #(.N(N)) b1 ();
  alu_arbiter_if #(.N(N)) b3 ();

  logic [N-1:0] a1_a, a1_b, a1_res, a3_a, a3_b, a3_res;
  logic [3:0]   a1_ctrl, a1_flags, a3_ctrl, a3_flags;
  logic         busy1, busy3;
  state_e       st1, st3;

  alu_arbiter #(.N(N), .ALU_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .bus(b1),
    .alu_a(a1_a), .alu_b(a1_b), .alu_ctrl(a1_ctrl),
    .alu_result(a1_res), .alu_flags(a1_flags),
    .busy(busy1), .dbg_state(st1)
  );

  alu_arbiter #(.N(N), .ALU_LAT(3)) dut3 (
    .clock(clock), .reset(reset), .bus(b3),
    .alu_a(a3_a), .alu_b(a3_b), .alu_ctrl(a3_ctrl),
    .alu_result(a3_res), .alu_flags(a3_flags),
    .busy(busy3), .dbg_state(st3)
  );

  // ALU model: {flags, result}; 0=add, 2=and, 3=or, else pass a
  function automatic logic [11:0] alu_f(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic cy, ov;
    cy = 1'b0;
    ov = 1'b0;
    case (c)
      4'h0: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[7:0];
        cy = s[8];
        ov = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      default: r = a;
    endcase
    return {r[7], (r == 8'h00), cy, ov, r};
  endfunction

  always_comb {a1_flags, a1_res} = alu_f(a1_ctrl, a1_a, a1_b);

  // second ALU answers two cycles after its operands change
  logic [11:0] p3_s1, p3_s2;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      p3_s1 <= '0;
      p3_s2 <= '0;
    end else begin
      p3_s1 <= alu_f(a3_ctrl, a3_a, a3_b);
      p3_s2 <= p3_s1;
    end
  end
  assign {a3_flags, a3_res} = p3_s2;

  // scoreboard: entries are {id, flags, data}
  logic [12:0] exp_q1[$];
  logic [12:0] exp_q3[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // monitor
  always @(negedge clock) begin
    logic [12:0] e;
    if (!reset && b1.rsp_valid && b1.rsp_ready) begin
      if (exp_q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1_unexpected_rsp: got id=%0d data=%0h, expected no response", b1.rsp_id, b1.rsp_data);
      end else begin
        e = exp_q1.pop_front();
        check("dut1_rsp", {19'd0, b1.rsp_id, b1.rsp_flags, b1.rsp_data}, {19'd0, e});
      end
    end
    if (!reset && b3.rsp_valid && b3.rsp_ready) begin
      if (exp_q3.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut3_unexpected_rsp: got id=%0d data=%0h, expected no response", b3.rsp_id, b3.rsp_data);
      end else begin
        e = exp_q3.pop_front();
        check("dut3_rsp", {19'd0, b3.rsp_id, b3.rsp_flags, b3.rsp_data}, {19'd0, e});
      end
    end
  end

  // bounded wait for a grant; returns granted id and the cycle it was seen
  task automatic wait_grant(input int d, output logic id, output int at);
    logic [1:0] rdy;
    id = 1'bx;
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      rdy = (d == 1) ? b1.req_ready : b3.req_ready;
      if (rdy != 2'b00) begin
        id = rdy[1];
        at = cyc;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL grant_timeout: dut%0d got no grant, expected one within 20 cycles", d);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    logic gid;
    int   t, tp, tr, lat;
    int   exp_ids[4];
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_ids = '{0, 0, 0, 0};
`else
    exp_ids = '{0, 1, 0, 1};
`endif
    tp = 0;
    reset = 1'b1;
    b1.req_valid = 2'b11; b1.req_a = '0; b1.req_b = '0; b1.req_ctrl = '0; b1.rsp_ready = 1'b0;
    b3.req_valid = 2'b00; b3.req_a = '0; b3.req_b = '0; b3.req_ctrl = '0; b3.rsp_ready = 1'b0;
    step();
    step();
    check("rst_req_ready", 32'(b1.req_ready), 0);
    check("rst_rsp_valid", 32'(b1.rsp_valid), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_alu_a", 32'(a1_a), 0);
    check("rst_alu_ctrl", 32'(a1_ctrl), 0);
    check("rst_rsp_data", 32'(b1.rsp_data), 0);
    check("rst_state", 32'(st1), 32'(IDLE));
    b1.req_valid = 2'b00;
    @(negedge clock);
    reset = 1'b0;
    step();
    b1.rsp_ready = 1'b1;
    b3.rsp_ready = 1'b1;

    // single request: 05 + 03
    b1.req_a[0] = 8'h05; b1.req_b[0] = 8'h03; b1.req_ctrl[0] = 4'h0; b1.req_valid = 2'b01;
    wait_grant(1, gid, t);
    check("single_grant", 32'(gid), 0);
    exp_q1.push_back({1'b0, 4'b0000, 8'h08});
    step();
    b1.req_valid = 2'b00;
    check("single_alu_a", 32'(a1_a), 32'h05);
    check("single_alu_b", 32'(a1_b), 32'h03);
    check("single_no_rsp_yet", 32'(b1.rsp_valid), 0);
    step();
    check("single_rsp_valid", 32'(b1.rsp_valid), 1);
    check("single_busy", 32'(busy1), 1);
    step();
    check("single_rsp_done", 32'(b1.rsp_valid), 0);
    check("single_idle", 32'(st1), 32'(IDLE));

    // backpressure: req1 3C & 0F held in RESP, req0 waits
    b1.rsp_ready = 1'b0;
    b1.req_a[1] = 8'h3C; b1.req_b[1] = 8'h0F; b1.req_ctrl[1] = 4'h2; b1.req_valid = 2'b10;
    wait_grant(1, gid, t);
    check("bp_grant", 32'(gid), 1);
    exp_q1.push_back({1'b1, 4'b0000, 8'h0C});
    step();
    b1.req_a[0] = 8'h10; b1.req_b[0] = 8'h20; b1.req_ctrl[0] = 4'h0; b1.req_valid = 2'b01;
    check("bp_exec_ready", 32'(b1.req_ready), 0);
    step();
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 32'(b1.rsp_valid), 1);
      check("bp_rsp_data", 32'(b1.rsp_data), 32'h0C);
      check("bp_rsp_flags", 32'(b1.rsp_flags), 0);
      check("bp_alu_a", 32'(a1_a), 32'h3C);
      check("bp_req_ready", 32'(b1.req_ready), 0);
      step();
    end
    b1.rsp_ready = 1'b1;
    tr = cyc;
    wait_grant(1, gid, t);
    check("bp_next_grant", 32'(gid), 0);
    check("bp_grant_gap", 32'(t - tr), 1);
    exp_q1.push_back({1'b0, 4'b0000, 8'h30});
    step();
    b1.req_valid = 2'b00;
    repeat (3) step();

    // reset while executing
    b1.req_a[0] = 8'h01; b1.req_b[0] = 8'h01; b1.req_ctrl[0] = 4'h0; b1.req_valid = 2'b01;
    wait_grant(1, gid, t);
    step();
    b1.req_valid = 2'b00;
    reset = 1'b1;
    #1;
    check("mid_rst_rsp_valid", 32'(b1.rsp_valid), 0);
    check("mid_rst_busy", 32'(busy1), 0);
    check("mid_rst_alu_a", 32'(a1_a), 0);
    check("mid_rst_state", 32'(st1), 32'(IDLE));
    @(negedge clock);
    reset = 1'b0;
    repeat (4) step();
    check("mid_rst_no_rsp", 32'(b1.rsp_valid), 0);

    // contention: req0 10+20, req1 7F+01
    b1.req_a[0] = 8'h10; b1.req_b[0] = 8'h20; b1.req_ctrl[0] = 4'h0;
    b1.req_a[1] = 8'h7F; b1.req_b[1] = 8'h01; b1.req_ctrl[1] = 4'h0;
    b1.req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_grant(1, gid, t);
      check("cont_grant", 32'(gid), 32'(exp_ids[i]));
      if (i > 0) check("cont_gap", 32'(t - tp), 3);
      tp = t;
      if (exp_ids[i] == 0) exp_q1.push_back({1'b0, 4'b0000, 8'h30});
      else                 exp_q1.push_back({1'b1, 4'b1001, 8'h80});
      step();
    end
    b1.req_valid = 2'b10;
    wait_grant(1, gid, t);
    check("cont_req1_after_drop", 32'(gid), 1);
    exp_q1.push_back({1'b1, 4'b1001, 8'h80});
    step();
    b1.req_valid = 2'b00;
    repeat (4) step();

    // latency 3: A0 + 05 arrives from the ALU two cycles after operands
    b3.req_a[0] = 8'hA0; b3.req_b[0] = 8'h05; b3.req_ctrl[0] = 4'h0; b3.req_valid = 2'b01;
    wait_grant(3, gid, t);
    check("lat3_grant", 32'(gid), 0);
    exp_q3.push_back({1'b0, 4'b1000, 8'hA5});
    step();
    b3.req_valid = 2'b00;
    check("lat3_alu_a", 32'(a3_a), 32'hA0);
    lat = 1;
    while (!b3.rsp_valid && lat < 12) begin
      step();
      lat++;
    end
    check("lat3_cycles", 32'(lat), 4);
    check("lat3_rsp_data", 32'(b3.rsp_data), 32'hA5);
    check("lat3_rsp_flags", 32'(b3.rsp_flags), 32'b1000);

    repeat (5) step();
    check("q1_drained", 32'(exp_q1.size()), 0);
    check("q3_drained", 32'(exp_q3.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
